// File: rtl/lcd_host_driver_pkg.sv
// ----------------------------------------------------------------------------
// lcd_host_driver_pkg
//   Shared definitions for the LCD host driver:
//   - command codes understood by the LCD controller
//   - driver FSM state encoding
//   - default sizes (image pixels, output burst length, beat timeout)
//   - counter widths and a legality helper for command codes
// ----------------------------------------------------------------------------
package lcd_host_driver_pkg;

    // Command codes; anything above CMD_SHIFT_D is illegal.
    localparam logic [3:0] CMD_LOAD     = 4'd0;
    localparam logic [3:0] CMD_ROT_L    = 4'd1;
    localparam logic [3:0] CMD_ROT_R    = 4'd2;
    localparam logic [3:0] CMD_ZOOM_IN  = 4'd3;
    localparam logic [3:0] CMD_ZOOM_FIT = 4'd4;
    localparam logic [3:0] CMD_SHIFT_R  = 4'd5;
    localparam logic [3:0] CMD_SHIFT_L  = 4'd6;
    localparam logic [3:0] CMD_SHIFT_U  = 4'd7;
    localparam logic [3:0] CMD_SHIFT_D  = 4'd8;

    localparam int IMG_PIXELS_DEF = 108;   // 12x9 image
    localparam int OUT_PIXELS_DEF = 16;    // output burst per command
    localparam int TIMEOUT_DEF    = 1023;  // idle cycles before giving up

    localparam int PIX_W  = 7;   // pixel / ROM address counter
    localparam int BEAT_W = 4;   // output beat counter
    localparam int TMR_W  = 10;  // timeout counter

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOAD_DATA = 2'd2,
        ST_WAIT_OUT  = 2'd3
    } state_e;

    function automatic logic cmd_legal(input logic [3:0] c);
        return (c <= CMD_SHIFT_D);
    endfunction

endpackage

// File: rtl/lcd_host_driver_if.sv
// ----------------------------------------------------------------------------
// lcd_host_driver_if
//   Bundles every non-clock signal of the LCD host driver:
//   request source (req_*), image ROM (img_*), LCD controller command and
//   data path (cmd*, datain, busy, dataout, output_valid) and result sink
//   (res_*, done, err).
//   master : the driver itself
//   slave  : the environment (script source, ROM, controller, sink)
// ----------------------------------------------------------------------------
interface lcd_host_driver_if;
    logic       req_valid;
    logic [3:0] req_cmd;
    logic       req_ready;

    logic [6:0] img_addr;
    logic       img_rd;
    logic [7:0] img_data;

    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy;
    logic [7:0] dataout;
    logic       output_valid;

    logic [7:0] res_data;
    logic [3:0] res_idx;
    logic       res_valid;
    logic       done;
    logic       err;

    modport master (
        input  req_valid, req_cmd, img_data, busy, dataout, output_valid,
        output req_ready, img_addr, img_rd, cmd, cmd_valid, datain,
               res_data, res_idx, res_valid, done, err
    );

    modport slave (
        output req_valid, req_cmd, img_data, busy, dataout, output_valid,
        input  req_ready, img_addr, img_rd, cmd, cmd_valid, datain,
               res_data, res_idx, res_valid, done, err
    );
endinterface

// File: rtl/lcd_host_driver_beat_timer.sv
// ----------------------------------------------------------------------------
// lcd_beat_timer
//   Loadable idle-cycle counter used to detect a stalled output burst.
//   Ports:
//     clk, reset  clock, async active-low reset
//     clr         force count to 0 (highest priority)
//     ld, ld_val  load count with ld_val
//     en          count up by one
//     expire      high in the cycle whose increment would reach LIMIT
//   expire is combinational so a registered error flag lands exactly LIMIT
//   cycles after the reference point.
// ----------------------------------------------------------------------------
module lcd_beat_timer #(
    parameter int LIMIT = 1023,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] cnt;

    assign expire = en && !clr && !ld && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= '0;
        else if (clr)     cnt <= '0;
        else if (ld)      cnt <= ld_val;
        else if (en)      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/lcd_host_driver.sv
// ----------------------------------------------------------------------------
// lcd_host_driver
//   Initiator for the LCD controller command interface. Takes one request at
//   a time from a command script, strobes it onto cmd/cmd_valid, streams the
//   image ROM on LOAD, then collects the 16-beat output burst into the result
//   sink. Pulses done after the last beat, err on an illegal code or when the
//   burst stalls for TIMEOUT cycles.
//   Ports:
//     clk    system clock (rising edge)
//     reset  async active-low reset
//     bus    lcd_host_driver_if.master (request, ROM, controller, result)
// ----------------------------------------------------------------------------
module lcd_host_driver
    import lcd_host_driver_pkg::*;
#(
    parameter int IMG_PIXELS = IMG_PIXELS_DEF,
    parameter int OUT_PIXELS = OUT_PIXELS_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    lcd_host_driver_if.master bus
);
    state_e state, state_n;

    logic [3:0]        cmd_q;
    logic              cmd_valid_q;
    logic              img_rd_q;
    logic [PIX_W-1:0]  img_addr_q;
    logic [PIX_W-1:0]  pix_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [7:0]        res_data_q;
    logic [BEAT_W-1:0] res_idx_q;
    logic              res_valid_q;
    logic              done_q;
    logic              err_q;

    logic accept, issue_ok, beat, last_beat, pix_last;
    logic tmr_clr, tmr_ld, tmr_en, tmr_expire;

    // No acceptance in the done cycle keeps the result sink from seeing a
    // new command's strobe overlap the previous burst's completion.
    assign bus.req_ready = reset && (state == ST_IDLE) && !bus.busy && !done_q;

    assign pix_last = (pix_cnt == PIX_W'(IMG_PIXELS - 1));
    // Kept outside the FSM process: expire feeds back into next-state.
    assign tmr_en   = (state == ST_WAIT_OUT) && !bus.output_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        issue_ok  = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        tmr_clr   = 1'b0;
        tmr_ld    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = bus.req_valid && bus.req_ready;
                if (accept && cmd_legal(bus.req_cmd)) begin
                    issue_ok = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_q == CMD_LOAD) begin
                    state_n = ST_LOAD_DATA;
                end else begin
                    state_n = ST_WAIT_OUT;
                    tmr_clr = 1'b1;
                end
            end
            ST_LOAD_DATA: begin
                if (pix_last) begin
                    state_n = ST_WAIT_OUT;
                    tmr_clr = 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                if (bus.output_valid) begin
                    beat   = 1'b1;
                    // The beat cycle is the reference; the next cycle is
                    // already one idle cycle after it.
                    tmr_ld = 1'b1;
                    if (beat_cnt == BEAT_W'(OUT_PIXELS - 1)) begin
                        last_beat = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end else if (tmr_expire) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    lcd_beat_timer #(.LIMIT(TIMEOUT), .W(TMR_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .ld     (tmr_ld),
        .ld_val (TMR_W'(1)),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            img_rd_q    <= 1'b0;
            img_addr_q  <= '0;
            pix_cnt     <= '0;
            beat_cnt    <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_valid_q <= issue_ok;
            if (issue_ok) cmd_q <= bus.req_cmd;

            err_q <= (accept && !issue_ok) || tmr_expire;

            // ROM reads start in the issue cycle so pixel 0 lines up with
            // the first LOAD_DATA cycle.
            if (issue_ok && bus.req_cmd == CMD_LOAD) begin
                img_rd_q   <= 1'b1;
                img_addr_q <= '0;
            end else if (img_rd_q) begin
                if (img_addr_q == PIX_W'(IMG_PIXELS - 1)) begin
                    img_rd_q   <= 1'b0;
                    img_addr_q <= '0;
                end else begin
                    img_addr_q <= img_addr_q + 1'b1;
                end
            end

            if (state == ST_LOAD_DATA && !pix_last) pix_cnt <= pix_cnt + 1'b1;
            else                                    pix_cnt <= '0;

            if (beat)                                     beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            else if (state != ST_WAIT_OUT || tmr_expire)  beat_cnt <= '0;

            res_valid_q <= beat;
            done_q      <= last_beat;
            if (beat) begin
                res_data_q <= bus.dataout;
                res_idx_q  <= beat_cnt;
            end
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.img_rd    = img_rd_q;
    assign bus.img_addr  = img_addr_q;
    assign bus.datain    = (state == ST_LOAD_DATA) ? bus.img_data : 8'h00;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_valid = res_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_lcd_host_driver.sv
// ----------------------------------------------------------------------------
// tb_lcd_host_driver
//   Scoreboard bench: the stimulus side computes, from the protocol rules,
//   every strobe the driver should produce (command issue, result beats,
//   errors) with its expected sample time, and queues it. An independent
//   monitor pops and compares whenever the driver raises a strobe, and checks
//   the datain stream against the bench's own ROM image after a LOAD issue.
// ----------------------------------------------------------------------------
module tb_lcd_host_driver;
    import lcd_host_driver_pkg::*;

    localparam int IMG = 108;
    localparam int OUT = 16;
    localparam int TO  = 1023;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lcd_host_driver_if bus();

    lcd_host_driver #(.IMG_PIXELS(IMG), .OUT_PIXELS(OUT), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {EV_CMD, EV_RES, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
        logic [3:0] idx;
        logic       dn;
        longint     t;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] rom [0:IMG-1];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    endtask

    // Synchronous image ROM: data one cycle after the read strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset)          bus.img_data <= 8'h00;
        else if (bus.img_rd) bus.img_data <= rom[bus.img_addr];
    end

    // ---------------- monitor ----------------
    int load_win = 0;
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            load_win = 0;
        end else begin
            if (load_win > 0) begin
                check("datain_pixel", bus.datain, rom[IMG - load_win]);
                load_win--;
            end else begin
                check("datain_idle", bus.datain, 0);
            end
            if (bus.cmd_valid) begin
                check("cmd_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("cmd_kind", int'(e.kind), int'(EV_CMD));
                    check("cmd_code", bus.cmd, e.data);
                    check("cmd_time", $time, e.t);
                    if (bus.cmd == CMD_LOAD) load_win = IMG;
                end
            end
            if (bus.res_valid) begin
                check("res_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("res_kind", int'(e.kind), int'(EV_RES));
                    check("res_data", bus.res_data, e.data);
                    check("res_idx", bus.res_idx, e.idx);
                    check("res_done", bus.done, e.dn);
                    check("res_time", $time, e.t);
                end
            end else begin
                check("done_without_res", bus.done, 0);
            end
            if (bus.err) begin
                check("err_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("err_kind", int'(e.kind), int'(EV_ERR));
                    check("err_time", $time, e.t);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_kind_e k, input logic [7:0] d, input logic [3:0] i,
                        input logic dn, input longint t);
        ev_t e;
        e.kind = k; e.data = d; e.idx = i; e.dn = dn; e.t = t;
        sb.push_back(e);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {bus.cmd, bus.cmd_valid, bus.img_addr, bus.img_rd, bus.datain,
                     bus.res_data, bus.res_idx, bus.res_valid, bus.done, bus.err,
                     bus.req_ready}, 0);
    endtask

    // Present a request until accepted; ta is the accepting clock edge.
    task automatic issue(input logic [3:0] c, output longint ta, output bit ok);
        bit r;
        ok = 0; ta = 0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            r = bus.req_ready;
            @(posedge clk);
            if (r) begin ta = $time; ok = 1; end
            #1;
        end
        bus.req_valid = 1'b0;
        check("req_accepted", ok, 1);
    endtask

    // Everything after acceptance: expected strobes, ROM phase, beats.
    task automatic finish_cmd(input logic [3:0] c, input longint ta, input int nb,
                              input bit seq, input bit noisy);
        longint tb = 0;
        logic [7:0] v;
        if (c > CMD_SHIFT_D) begin
            push(EV_ERR, 0, 0, 0, ta + 5);
            @(negedge clk);
            check("ready_after_illegal", bus.req_ready, 1);
            tick();
            return;
        end
        push(EV_CMD, {4'h0, c}, 0, 0, ta + 5);
        if (c == CMD_LOAD) begin
            // issue cycle plus 108 pixel cycles; any beat here is ignored
            for (int k = 0; k < IMG + 1; k++) begin
                bus.output_valid = noisy & 1'($urandom_range(0, 1));
                bus.dataout      = 8'($urandom);
                tick();
            end
            bus.output_valid = 1'b0;
        end else begin
            tick();
        end
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            v = seq ? 8'(8'hA0 + b) : 8'($urandom);
            bus.output_valid = 1'b1;
            bus.dataout      = v;
            push(EV_RES, v, 4'(b), (b == OUT - 1), $time - 1 + 15);
            tick();
            bus.output_valid = 1'b0;
            tb = $time - 1;
        end
        if (nb < OUT) begin
            push(EV_ERR, 0, 0, 0, tb + longint'(TO - 1) * 10 + 5);
            repeat (TO + 3) tick();
        end else begin
            repeat (2) tick();
        end
    endtask

    task automatic do_cmd(input logic [3:0] c, input int nb, input bit seq, input bit noisy);
        longint ta; bit ok;
        issue(c, ta, ok);
        if (ok) finish_cmd(c, ta, nb, seq, noisy);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint ta, tdrop;
        bit ok;
        bus.req_valid = 1'b0; bus.req_cmd = '0; bus.busy = 1'b0;
        bus.dataout = '0; bus.output_valid = 1'b0;
        for (int i = 0; i < IMG; i++) rom[i] = 8'(i);

        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("reset_outputs");
        end
        tick();
        reset = 1'b1;
        tick();

        // LOAD with ROM[i]=i and beats 0xA0..0xAF
        do_cmd(CMD_LOAD, OUT, 1, 0);

        // ROT_R held off by busy for five cycles
        bus.busy = 1'b1; bus.req_valid = 1'b1; bus.req_cmd = CMD_ROT_R;
        repeat (5) begin
            @(negedge clk);
            check("ready_while_busy", bus.req_ready, 0);
            tick();
        end
        tdrop = $time - 1;
        bus.busy = 1'b0;
        issue(CMD_ROT_R, ta, ok);
        check("busy_release_accept", ta, tdrop + 10);
        if (ok) finish_cmd(CMD_ROT_R, ta, OUT, 0, 0);

        // illegal code
        do_cmd(4'd11, 0, 0, 0);

        // SHIFT_R with a truncated burst
        do_cmd(CMD_SHIFT_R, 7, 0, 0);

        // LOAD with random image and beats sprinkled over the load phase
        for (int i = 0; i < IMG; i++) rom[i] = 8'($urandom);
        do_cmd(CMD_LOAD, OUT, 0, 1);

        // random legal non-LOAD commands
        repeat (5) do_cmd(4'($urandom_range(1, 8)), OUT, 0, 0);

        // reset in the middle of a LOAD (after 40 pixels)
        issue(CMD_LOAD, ta, ok);
        if (ok) push(EV_CMD, 8'(CMD_LOAD), 0, 0, ta + 5);
        repeat (41) tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("midload_reset_outputs");
            tick();
        end
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.req_ready, 1);
        repeat (20) tick();

        // recovery
        do_cmd(CMD_ZOOM_IN, OUT, 0, 0);

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
